slicer_offset_cal: RTL and testbench
====================================

Name: slicer_offset_cal

Overview:
- Digital calibration controller for the comparator slicer stage.
- During calibration the slicer input is shorted to common mode. The block then runs a successive-approximation search on the slicer's reference DAC code. It finds the code at which the slicer output changes from mostly-1 to mostly-0, which cancels the input-referred offset.
- Result is held on ref_code for normal operation. A manual override path is provided for bring-up.

Parameters:
- CODE_W, 6, reference DAC code width; midscale = 1<<(CODE_W-1).
- WIN_LEN, 64, slice_out samples counted per trial; must be even and >= 2.
- SETTLE_CYC, 4, idle cycles after each ref_code change before counting starts; >= 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE; launches a calibration.
- slice_out  input  1  sampled slicer decision; 1 = input above reference.
- man_en  input  1  manual override enable; honoured only in IDLE.
- man_code  input  CODE_W  manual reference code.
- ref_code  output  CODE_W  drives the slicer reference DAC.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the search completes.
- cal_fail  output  1  sticky until next accepted start or rst; result saturated.

Behaviour:
- Reset values: ref_code = midscale, cal_reg = midscale, busy = 0, done = 0, cal_fail = 0, state = IDLE, all counters = 0.
- rst is asserted mid-operation: the next edge returns to reset values. No done pulse; the partial result is discarded.
- States and transitions:
  - IDLE: start = 1 clears cal_fail and sets trial = midscale (bit CODE_W-1 set, others 0), bit index = CODE_W-1, then goes to SETTLE.
  - SETTLE: lasts exactly SETTLE_CYC cycles; slice_out is ignored.
  - COUNT: lasts exactly WIN_LEN cycles. Each cycle adds slice_out into ones_cnt, which is sized to hold WIN_LEN.
  - DECIDE: one cycle.
    - If ones_cnt > WIN_LEN/2, the current bit stays 1; otherwise it is cleared. A tie clears the bit.
    - If bit index > 0: set the next-lower bit, decrement the index, clear ones_cnt, go to SETTLE.
    - If bit index = 0: store trial into cal_reg, go to DONE.
  - DONE: one cycle; done = 1, busy = 0. cal_fail = 1 if cal_reg is all-zeros or all-ones. Then IDLE.
- ref_code:
  - Equals trial in SETTLE, COUNT and DECIDE.
  - In IDLE and DONE it equals man_code if man_en = 1, else cal_reg.
  - man_en outside IDLE has no effect.
- Each trial takes SETTLE_CYC + WIN_LEN + 1 cycles.
- Latency: if start is sampled high at edge k, done is high in the cycle beginning at edge k + 1 + CODE_W*(SETTLE_CYC+WIN_LEN+1). With defaults this is 415 cycles.
- busy is high for all SETTLE, COUNT and DECIDE cycles.
- start while busy is ignored; no queuing.
- start held high through DONE does not retrigger in DONE. It is accepted again in the following IDLE cycle.
- ref_code changes only on the edge entering SETTLE, so the DAC sees at most one change per trial.

Test Plan:
- Slicer model slice_out = (ref_code <= 37), then pulse start → ref_code trial sequence 32, 48, 40, 36, 38, 37; final ref_code = 37; done exactly 415 cycles after start; cal_fail = 0.
- slice_out tied 1 → result 63, cal_fail = 1; tied 0 → result 0, cal_fail = 1; both cases still give done at 415.
- slice_out alternating 1/0 (exactly 32 ones per window) → every bit cleared by the tie rule → result 0, cal_fail = 1.
- rst asserted during the third COUNT phase → next cycle ref_code = 32, busy = 0, done never pulses. A fresh start then completes normally to 37.
- start re-pulsed while busy (e.g. at cycle 100) → no restart; done still at cycle 415 of the original run.
- Override:
  - After cal to 37, man_en = 1 with man_code = 10 → ref_code = 10 next cycle; man_en = 0 → ref_code = 37.
  - man_en = 1 asserted during busy → trial codes unaffected.

Source files
------------

// File: rtl/slicer_offset_cal.sv
// -----------------------------------------------------------------------------
// slicer_offset_cal
//
// Offset calibration controller for the comparator slicer. While the slicer
// input is shorted to common mode, a successive-approximation search walks
// the reference DAC code from MSB to LSB. For each trial code it waits for
// the DAC to settle, then counts slicer ones over a fixed window. A bit is
// kept only when ones are a strict majority. The final code is held on
// ref_code, and a manual override can replace it while the block is idle.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      level request; a calibration is launched from IDLE
//   slice_out  slicer decision (1 = input above reference)
//   man_en     manual override enable, honoured in IDLE/DONE only
//   man_code   manual reference code
//   ref_code   reference DAC code (registered)
//   busy       high for every SETTLE/COUNT/DECIDE cycle
//   done       one-cycle pulse in the DONE cycle
//   cal_fail   result hit a rail; sticky until the next accepted start
// -----------------------------------------------------------------------------
module slicer_offset_cal #(
  parameter int CODE_W     = 6,
  parameter int WIN_LEN    = 64,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              slice_out,
  input  logic              man_en,
  input  logic [CODE_W-1:0] man_code,
  output logic [CODE_W-1:0] ref_code,
  output logic              busy,
  output logic              done,
  output logic              cal_fail
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam int CYC_W = $clog2(WIN_LEN + SETTLE_CYC + 1);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  localparam logic [CODE_W-1:0] MID      = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CNT_W-1:0]  HALF_WIN = CNT_W'(WIN_LEN / 2);
  localparam logic [CYC_W-1:0]  SET_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0]  WIN_LAST = CYC_W'(WIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t            state_q,    state_d;
  logic              start_q,    start_d;
  logic [CODE_W-1:0] trial_q,    trial_d;
  logic [CODE_W-1:0] cal_reg_q,  cal_reg_d;
  logic [IDX_W-1:0]  bit_idx_q,  bit_idx_d;
  logic [CNT_W-1:0]  ones_cnt_q, ones_cnt_d;
  logic [CYC_W-1:0]  cyc_cnt_q,  cyc_cnt_d;
  logic [CODE_W-1:0] ref_code_q, ref_code_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              cal_fail_q, cal_fail_d;

  logic [CODE_W-1:0] bit_mask;
  logic              next_busy;

  // One-hot mask of the bit currently under test.
  assign bit_mask = CODE_W'(1) << bit_idx_q;

  always_comb begin
    state_d    = state_q;
    // start is registered once; the FSM acts on the registered copy, which
    // is what places done one cycle after CODE_W full trials.
    start_d    = start;
    trial_d    = trial_q;
    cal_reg_d  = cal_reg_q;
    bit_idx_d  = bit_idx_q;
    ones_cnt_d = ones_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    done_d     = 1'b0;
    cal_fail_d = cal_fail_q;

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          cal_fail_d = 1'b0;
          trial_d    = MID;
          bit_idx_d  = IDX_W'(CODE_W - 1);
          ones_cnt_d = '0;
          cyc_cnt_d  = '0;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cyc_cnt_q == SET_LAST) begin
          cyc_cnt_d = '0;
          state_d   = S_COUNT;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      S_COUNT: begin
        ones_cnt_d = ones_cnt_q + CNT_W'(slice_out);
        if (cyc_cnt_q == WIN_LAST) begin
          cyc_cnt_d = '0;
          state_d   = S_DECIDE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      S_DECIDE: begin
        // Strict majority keeps the bit; an exact tie clears it.
        if (!(ones_cnt_q > HALF_WIN)) begin
          trial_d = trial_q & ~bit_mask;
        end
        if (bit_idx_q != '0) begin
          trial_d    = trial_d | (bit_mask >> 1);
          bit_idx_d  = bit_idx_q - 1'b1;
          ones_cnt_d = '0;
          state_d    = S_SETTLE;
        end else begin
          cal_reg_d  = trial_d;
          done_d     = 1'b1;
          cal_fail_d = (trial_d == '0) || (trial_d == '1);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    next_busy = (state_d == S_SETTLE) || (state_d == S_COUNT) ||
                (state_d == S_DECIDE);
    busy_d    = next_busy;

    // During a search the DAC follows the trial code, which only moves on
    // the edge into SETTLE. The override is looked at only when the FSM is
    // currently idle (or finishing), so it can never disturb a trial.
    if (next_busy) begin
      ref_code_d = trial_d;
    end else if (((state_q == S_IDLE) || (state_q == S_DONE)) && man_en) begin
      ref_code_d = man_code;
    end else begin
      ref_code_d = cal_reg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      trial_q    <= MID;
      cal_reg_q  <= MID;
      bit_idx_q  <= '0;
      ones_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      ref_code_q <= MID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cal_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      trial_q    <= trial_d;
      cal_reg_q  <= cal_reg_d;
      bit_idx_q  <= bit_idx_d;
      ones_cnt_q <= ones_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      ref_code_q <= ref_code_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cal_fail_q <= cal_fail_d;
    end
  end

  assign ref_code = ref_code_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cal_fail = cal_fail_q;

endmodule

// File: tb/tb_slicer_offset_cal.sv
// -----------------------------------------------------------------------------
// tb_slicer_offset_cal
//
// Directed and randomized checks of slicer_offset_cal against a reference
// model of the successive-approximation search. The slicer is emulated from
// the current ref_code (threshold model, constant outputs or alternation).
// -----------------------------------------------------------------------------
module tb_slicer_offset_cal;

  localparam int CODE_W     = 6;
  localparam int WIN_LEN    = 64;
  localparam int SETTLE_CYC = 4;
  localparam int TRIAL      = SETTLE_CYC + WIN_LEN + 1;
  localparam int LAT        = 1 + CODE_W * TRIAL;
  localparam int MID        = 1 << (CODE_W - 1);
  localparam int MAXC       = (1 << CODE_W) - 1;

  localparam int M_THR  = 0;
  localparam int M_ONE  = 1;
  localparam int M_ZERO = 2;
  localparam int M_ALT  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              slice_out;
  logic              man_en;
  logic [CODE_W-1:0] man_code;
  logic [CODE_W-1:0] ref_code;
  logic              busy;
  logic              done;
  logic              cal_fail;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_seq[CODE_W];
  int exp_res;
  logic alt_bit = 1'b0;

  always #5 clk = ~clk;

  slicer_offset_cal #(
    .CODE_W    (CODE_W),
    .WIN_LEN   (WIN_LEN),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .slice_out(slice_out),
    .man_en   (man_en),
    .man_code (man_code),
    .ref_code (ref_code),
    .busy     (busy),
    .done     (done),
    .cal_fail (cal_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ones counted in one window when the slicer sees reference 'code'.
  function automatic int ones_in_window(input int mode, input int thr, input int code);
    case (mode)
      M_THR:   return (code <= thr) ? WIN_LEN : 0;
      M_ONE:   return WIN_LEN;
      M_ZERO:  return 0;
      default: return WIN_LEN / 2;
    endcase
  endfunction

  // Build the result MSB first: each trial is the code so far plus the
  // bit under test; the bit is kept on a strict majority of ones.
  task automatic model(input int mode, input int thr);
    int code;
    int trial;
    code = 0;
    for (int b = CODE_W - 1; b >= 0; b--) begin
      trial = code + (1 << b);
      exp_seq[CODE_W - 1 - b] = trial;
      if (2 * ones_in_window(mode, thr, trial) > WIN_LEN) code = trial;
    end
    exp_res = code;
  endtask

  task automatic drive_slice(input int mode, input int thr);
    alt_bit = ~alt_bit;
    case (mode)
      M_THR:   slice_out = (int'(ref_code) <= thr);
      M_ONE:   slice_out = 1'b1;
      M_ZERO:  slice_out = 1'b0;
      default: slice_out = alt_bit;
    endcase
  endtask

  // Run one calibration. restart_at re-pulses start at that cycle (0 = never);
  // man_busy holds a random override active throughout the search.
  task automatic run_cal(input string tag, input int mode, input int thr,
                         input int restart_at, input bit man_busy);
    int exp_fail;
    model(mode, thr);
    exp_fail = (exp_res == 0 || exp_res == MAXC) ? 1 : 0;
    start = 1'b1;
    drive_slice(mode, thr);
    @(posedge clk);
    #1;
    start = 1'b0;
    drive_slice(mode, thr);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s busy@%0d", tag, i), busy, (i < LAT) ? 1 : 0);
      chk($sformatf("%s done@%0d", tag, i), done, (i == LAT) ? 1 : 0);
      if (i < LAT)
        chk($sformatf("%s trial@%0d", tag, i), ref_code, exp_seq[(i - 1) / TRIAL]);
      if (i == 1)
        chk($sformatf("%s fail_clr", tag), cal_fail, 0);
      if (i == LAT) begin
        chk($sformatf("%s result", tag), ref_code, exp_res);
        chk($sformatf("%s cal_fail", tag), cal_fail, exp_fail);
      end
      start = (i == restart_at);
      if (man_busy && i < LAT) begin
        man_en   = 1'b1;
        man_code = CODE_W'($urandom);
      end else begin
        man_en = 1'b0;
      end
      drive_slice(mode, thr);
    end
    @(posedge clk);
    #1;
    chk($sformatf("%s idle_done", tag), done, 0);
    chk($sformatf("%s idle_ref", tag), ref_code, exp_res);
    chk($sformatf("%s idle_fail", tag), cal_fail, exp_fail);
  endtask

  initial begin
    int thr;
    int done_cnt;
    rst       = 1'b1;
    start     = 1'b0;
    slice_out = 1'b0;
    man_en    = 1'b0;
    man_code  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ref_code", ref_code, MID);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst cal_fail", cal_fail, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst ref_code", ref_code, MID);

    run_cal("thr37", M_THR, 37, 0, 1'b0);

    man_en   = 1'b1;
    man_code = 6'd10;
    @(posedge clk);
    #1;
    chk("override on", ref_code, 10);
    man_en = 1'b0;
    @(posedge clk);
    #1;
    chk("override off", ref_code, 37);

    run_cal("ones", M_ONE, 0, 0, 1'b0);
    run_cal("zeros", M_ZERO, 0, 0, 1'b0);
    run_cal("alt", M_ALT, 0, 0, 1'b0);
    run_cal("restart", M_THR, 37, 100, 1'b0);
    run_cal("man_busy", M_THR, int'($urandom_range(0, MAXC)), 0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      thr = int'($urandom_range(0, MAXC));
      run_cal($sformatf("rand%0d_thr%0d", r, thr), M_THR, thr, 0, 1'b0);
    end

    // Reset in the middle of the third COUNT window.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i < 1 + 2 * TRIAL + SETTLE_CYC + 10; i++) begin
      @(posedge clk);
      #1;
      slice_out = (int'(ref_code) <= 37);
    end
    chk("mid busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort ref_code", ref_code, MID);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort cal_fail", cal_fail, 0);
    done_cnt = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("abort no_done", done_cnt, 0);
    chk("abort idle_ref", ref_code, MID);
    run_cal("after_abort", M_THR, 37, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
